modexp_seq: RTL and testbench
=============================

// Module: modexp_seq
// PURPOSE
//  Square-and-multiply sequencer for RSA modular exponentiation (left-to-right binary method).
//  Drives one shared Montgomery multiplier (MM) through a start/done handshake.
//  Takes a base already in the Montgomery domain and R mod N, and returns base^exp mod N in the normal domain.
//  Sits between the long_div pre-reduction stage and the RSA top level.
// PARAMETERS
//  WIDTH  32  operand, modulus and exponent width
//  LEN_W  6   width of len port; must hold WIDTH
// PORTS
//  clk      in   1      system clock, rising edge
//  rstn     in   1      asynchronous, active-low reset
//  start    in   1      request pulse; sampled only in IDLE
//  base_m   in   WIDTH  base in Montgomery form (base*R mod N)
//  one_m    in   WIDTH  R mod N (Montgomery 1)
//  n        in   WIDTH  modulus, odd
//  exp      in   WIDTH  exponent
//  len      in   LEN_W  exponent bits to process, exp[len-1:0]
//  busy     out  1      high from accepted start until done
//  done     out  1      one-cycle pulse, result valid
//  result   out  WIDTH  base^exp mod N, normal domain
//  mm_start out  1      one-cycle issue pulse to the MM
//  mm_a     out  WIDTH  MM operand A
//  mm_b     out  WIDTH  MM operand B
//  mm_n     out  WIDTH  MM modulus (latched n)
//  mm_done  in   1      MM completion pulse
//  mm_res   in   WIDTH  MM result, valid when mm_done=1
// BEHAVIOUR
//  Reset: state=IDLE; busy, done and mm_start are 0; result, mm_a, mm_b and mm_n are 0.
//   The reset is asynchronous and may occur mid-operation: the operation is abandoned and no done is produced.
//  Accept: start=1 in IDLE latches base_m, n and exp. acc<=one_m, idx<=min(len,WIDTH). busy rises next cycle.
//   start outside IDLE is ignored; it is neither queued nor errored.
//  FSM: IDLE -> CHECK -> SQ_ISSUE -> SQ_WAIT -> (MUL_ISSUE -> MUL_WAIT) -> CHECK ... -> CV_ISSUE -> CV_WAIT -> DONE -> IDLE
//   CHECK: idx==0 -> CV_ISSUE; else idx<=idx-1 -> SQ_ISSUE.
//   SQ_ISSUE: mm_a=mm_b=acc, mm_start=1 for one cycle.
//   SQ_WAIT: on mm_done, acc<=mm_res. Next state is MUL_ISSUE if exp[idx]=1, else CHECK.
//   MUL_ISSUE: mm_a=acc, mm_b=base_m latch, mm_start=1.
//   MUL_WAIT: on mm_done, acc<=mm_res, then CHECK.
//   CV_ISSUE: mm_a=acc, mm_b=1 (Montgomery-to-normal conversion).
//   CV_WAIT: on mm_done, result<=mm_res, then DONE.
//   DONE: done=1 for one cycle, busy<=0, then IDLE.
//  Handshake rules:
//   mm_a, mm_b and mm_n are held stable from the issue cycle until mm_done is sampled.
//   mm_done is honoured only in *_WAIT states. mm_done in the issue cycle or in any other state is ignored.
//   No new issue occurs before the previous mm_done. At most one MM operation is outstanding.
//  Op count = L squares + popcount(exp[L-1:0]) multiplies + 1 conversion, where L=min(len,WIDTH).
//  len=0 -> only the conversion of one_m is issued -> result=1.
//  exp=0 with len>0 -> L squares of one_m, then conversion -> result=1.
//  result holds its value from DONE until the next completed operation. It is not cleared by start.
//  No leading-zero skip; timing depends only on len and popcount, never on mm_res.
//  Overhead per square/multiply: 2 cycles plus MM latency. Controller start-to-first-mm_start: 3 cycles.
// STRUCTURE
//  Shared package rsa_pkg:
//   state encoding localparams (IDLE, CHECK, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, CV_ISSUE, CV_WAIT, DONE)
//   WIDTH and LEN_W defaults
//  Single module, no sub-module. The MM instance lives in the parent so it can be shared with other users.
// TESTING
//  Bench MM model: a*b*R^-1 mod N with R=2^WIDTH, latency configurable 1..40 cycles.
//  Reference model computes results and checks every mm_a/mm_b against the expected sequence.
//  1) N=143, base=7 (as base*R mod N), exp=4'b1011, len=4
//     -> 8 mm_start pulses (S,M,S,S,M,S,M,CV), result=106, exactly one done pulse.
//  2) len=0, exp=0xFFFFFFFF -> exactly 1 mm_start with mm_b=1 -> result=1.
//  3) exp=0, len=4 -> 5 mm_start pulses -> result=1. Then exp=0xFFFFFFFF, len=40 -> clamped to 32 squares + 32 multiplies.
//  4) Second start pulse while busy, and mm_done injected during an issue cycle and in IDLE
//     -> both ignored; op count and result are unchanged from the clean run.
//  5) rstn asserted during SQ_WAIT -> outputs 0 immediately; no done.
//     A new start after release gives the correct result.
//  6) Case 1 rerun with MM latency 1 and latency 40 -> identical result and op sequence.
//     busy high throughout; mm_a/mm_b stable during every wait.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: default widths and the modexp
// sequencer state encoding.
package rsa_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_LEN_W = 6;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    SQ_ISSUE,
    SQ_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    CV_ISSUE,
    CV_WAIT,
    DONE
  } modexp_state_t;

endpackage

// File: rtl/modexp_seq.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery
// multiplier through a start/done handshake.
module modexp_seq
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] base_m,
  input  logic [WIDTH-1:0] one_m,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] exp,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_n,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_res
);

  localparam int IDX_W = $clog2(WIDTH);

  modexp_state_t    state, state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base_l;
  logic [WIDTH-1:0] exp_l;
  logic [LEN_W-1:0] idx;
  logic             exp_bit;

  // idx has already been decremented in CHECK, so it addresses the current bit.
  assign exp_bit = exp_l[idx[IDX_W-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      acc    <= '0;
      base_l <= '0;
      exp_l  <= '0;
      mm_n   <= '0;
      idx    <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_l <= base_m;
            exp_l  <= exp;
            mm_n   <= n;
            acc    <= one_m;
            idx    <= (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
          end
        end
        CHECK: begin
          if (idx != '0) idx <= idx - LEN_W'(1);
        end
        SQ_WAIT, MUL_WAIT: begin
          if (mm_done) acc <= mm_res;
        end
        CV_WAIT: begin
          if (mm_done) result <= mm_res;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    mm_start = 1'b0;
    mm_a     = '0;
    mm_b     = '0;
    unique case (state)
      IDLE:  if (start) state_nx = CHECK;
      CHECK: state_nx = (idx == '0) ? CV_ISSUE : SQ_ISSUE;
      SQ_ISSUE: begin
        mm_start = 1'b1;
        mm_a     = acc;
        mm_b     = acc;
        state_nx = SQ_WAIT;
      end
      SQ_WAIT: begin
        mm_a = acc;
        mm_b = acc;
        if (mm_done) state_nx = exp_bit ? MUL_ISSUE : CHECK;
      end
      MUL_ISSUE: begin
        mm_start = 1'b1;
        mm_a     = acc;
        mm_b     = base_l;
        state_nx = MUL_WAIT;
      end
      MUL_WAIT: begin
        mm_a = acc;
        mm_b = base_l;
        if (mm_done) state_nx = CHECK;
      end
      // Multiplying by plain 1 strips the R factor and leaves the normal domain.
      CV_ISSUE: begin
        mm_start = 1'b1;
        mm_a     = acc;
        mm_b     = WIDTH'(1);
        state_nx = CV_WAIT;
      end
      CV_WAIT: begin
        mm_a = acc;
        mm_b = WIDTH'(1);
        if (mm_done) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_modexp_seq.sv
// Self-checking bench for modexp_seq: Montgomery multiplier model with variable
// latency, arithmetic reference for results and the expected operand sequence.
module tb_modexp_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start = 1'b0;
  logic [31:0] base_m = '0, one_m = '0, n = '0, exp = '0;
  logic [5:0]  len = '0;
  logic        busy, done, mm_start, mm_done;
  logic [31:0] result, mm_a, mm_b, mm_n, mm_res;

  modexp_seq dut (
    .clk(clk), .rstn(rstn), .start(start), .base_m(base_m), .one_m(one_m),
    .n(n), .exp(exp), .len(len), .busy(busy), .done(done), .result(result),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_done(mm_done), .mm_res(mm_res)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // a*b*2^-32 mod m, by halving modulo the odd m thirty-two times.
  function automatic logic [31:0] mont(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] m);
    logic [63:0] x;
    x = (64'(a) * 64'(b)) % 64'(m);
    for (int i = 0; i < 32; i++) x = x[0] ? (x + 64'(m)) >> 1 : x >> 1;
    return x[31:0];
  endfunction

  function automatic logic [31:0] to_m(input logic [31:0] x, input logic [31:0] m);
    logic [63:0] t;
    t = (64'(x) << 32) % 64'(m);
    return t[31:0];
  endfunction

  function automatic logic [31:0] powmod(input logic [31:0] b, input logic [31:0] e,
                                         input int l, input logic [31:0] m);
    logic [63:0] r;
    r = 64'd1 % 64'(m);
    for (int i = l - 1; i >= 0; i--) begin
      r = (r * r) % 64'(m);
      if (e[i]) r = (r * 64'(b)) % 64'(m);
    end
    return r[31:0];
  endfunction

  // Multiplier model: records every issue, checks operand stability and
  // overlap, answers after lat cycles. inj_en answers on issue cycles too.
  int          lat = 1;
  logic [31:0] q_a[$], q_b[$];
  bit          pending = 1'b0, unstable = 1'b0, overlap = 1'b0;
  bit          inj_en = 1'b0, inj_idle = 1'b0;
  int          cnt = 0, done_cnt = 0;
  logic [31:0] cap_a, cap_b, cap_n, res_m = '0;
  logic        mm_done_m = 1'b0, inj_issue = 1'b0;

  assign mm_done = mm_done_m | inj_issue | inj_idle;
  assign mm_res  = (inj_issue | inj_idle) ? 32'hDEAD_BEEF : res_m;

  always @(negedge clk) begin
    mm_done_m = 1'b0;
    inj_issue = 1'b0;
    if (done) done_cnt++;
    if (!rstn) pending = 1'b0;
    else if (pending) begin
      if (mm_a !== cap_a || mm_b !== cap_b || mm_n !== cap_n) unstable = 1'b1;
      if (mm_start) overlap = 1'b1;
      cnt--;
      if (cnt == 0) begin
        mm_done_m = 1'b1;
        res_m     = mont(cap_a, cap_b, cap_n);
        pending   = 1'b0;
      end
    end else if (mm_start) begin
      q_a.push_back(mm_a);
      q_b.push_back(mm_b);
      cap_a   = mm_a;
      cap_b   = mm_b;
      cap_n   = mm_n;
      pending = 1'b1;
      cnt     = lat;
      if (inj_en) inj_issue = 1'b1;
    end
  end

  task automatic run_op(input string tag, input logic [31:0] b, input logic [31:0] m,
                        input logic [31:0] e, input logic [5:0] l, input int latency,
                        input bit dbl);
    logic [31:0] ea[$], eb[$];
    logic [31:0] acc, bm, om;
    int          nl, q0, d0, nops;
    bit          busy_low, got_done;
    bm = to_m(b, m);
    om = to_m(32'd1, m);
    nl = (l > 6'd32) ? 32 : int'(l);
    acc = om;
    for (int i = nl - 1; i >= 0; i--) begin
      ea.push_back(acc); eb.push_back(acc); acc = mont(acc, acc, m);
      if (e[i]) begin
        ea.push_back(acc); eb.push_back(bm); acc = mont(acc, bm, m);
      end
    end
    ea.push_back(acc); eb.push_back(32'd1);
    lat = latency;
    q0  = q_a.size();
    d0  = done_cnt;
    @(negedge clk);
    base_m = bm; one_m = om; n = m; exp = e; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_low = 1'b0;
    got_done = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (!busy) busy_low = 1'b1;
      if (dbl && cyc == 6) begin
        start = 1'b1; base_m = ~bm; exp = ~e; len = 6'd40;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("%s/done_seen", tag), 64'(got_done), 64'd1);
    repeat (3) @(negedge clk);
    check($sformatf("%s/done_pulses", tag), 64'(done_cnt - d0), 64'd1);
    check($sformatf("%s/result", tag), 64'(result), 64'(powmod(b, e, nl, m)));
    check($sformatf("%s/busy_low", tag), 64'(busy_low), 64'd0);
    check($sformatf("%s/stable", tag), 64'(unstable), 64'd0);
    check($sformatf("%s/overlap", tag), 64'(overlap), 64'd0);
    nops = q_a.size() - q0;
    check($sformatf("%s/op_count", tag), 64'(nops), 64'(ea.size()));
    for (int i = 0; i < nops && i < ea.size(); i++) begin
      check($sformatf("%s/op%0d_a", tag, i), 64'(q_a[q0 + i]), 64'(ea[i]));
      check($sformatf("%s/op%0d_b", tag, i), 64'(q_b[q0 + i]), 64'(eb[i]));
    end
  endtask

  initial begin
    logic [31:0] m, b, e;
    logic [31:0] prev;
    int q0, d0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/done", 64'(done), 64'd0);
    check("rst/mm_start", 64'(mm_start), 64'd0);
    check("rst/result", 64'(result), 64'd0);
    check("rst/mm_a", 64'(mm_a), 64'd0);
    check("rst/mm_b", 64'(mm_b), 64'd0);
    check("rst/mm_n", 64'(mm_n), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    run_op("c1", 32'd7, 32'd143, 32'b1011, 6'd4, 3, 1'b0);
    check("c1/known_106", 64'(result), 64'd106);
    run_op("len0", 32'd7, 32'd143, 32'hFFFF_FFFF, 6'd0, 2, 1'b0);
    check("len0/one", 64'(result), 64'd1);
    run_op("exp0", 32'd7, 32'd143, 32'd0, 6'd4, 2, 1'b0);
    check("exp0/one", 64'(result), 64'd1);
    run_op("clamp", 32'd12345, 32'hF123_4567, 32'hFFFF_FFFF, 6'd40, 3, 1'b0);

    // Spurious mm_done in IDLE must not disturb the held result.
    prev = result;
    @(negedge clk); inj_idle = 1'b1;
    @(negedge clk); inj_idle = 1'b0;
    @(negedge clk);
    check("idle_inj/result", 64'(result), 64'(prev));
    check("idle_inj/busy", 64'(busy), 64'd0);

    inj_en = 1'b1;
    run_op("ignore", 32'd7, 32'd143, 32'b1011, 6'd4, 5, 1'b1);
    inj_en = 1'b0;
    check("ignore/known_106", 64'(result), 64'd106);

    // Reset during the first square's wait abandons the operation.
    lat = 10;
    q0  = q_a.size();
    @(negedge clk);
    base_m = to_m(32'd7, 32'd143); one_m = to_m(32'd1, 32'd143);
    n = 32'd143; exp = 32'b1011; len = 6'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && q_a.size() == q0; i++) @(negedge clk);
    check("mid_rst/issued", 64'(q_a.size() - q0), 64'd1);
    @(negedge clk);
    d0 = done_cnt;
    rstn = 1'b0;
    #1;
    check("mid_rst/busy", 64'(busy), 64'd0);
    check("mid_rst/mm_a", 64'(mm_a), 64'd0);
    check("mid_rst/mm_b", 64'(mm_b), 64'd0);
    check("mid_rst/mm_n", 64'(mm_n), 64'd0);
    check("mid_rst/result", 64'(result), 64'd0);
    repeat (20) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_rst/no_done", 64'(done_cnt - d0), 64'd0);
    check("mid_rst/idle", 64'(busy), 64'd0);
    run_op("after_rst", 32'd7, 32'd143, 32'b1011, 6'd4, 4, 1'b0);

    run_op("lat1", 32'd7, 32'd143, 32'b1011, 6'd4, 1, 1'b0);
    run_op("lat40", 32'd7, 32'd143, 32'b1011, 6'd4, 40, 1'b0);

    for (int k = 0; k < 6; k++) begin
      m = $urandom | 32'h0001_0001;
      b = $urandom % m;
      e = $urandom;
      run_op($sformatf("rnd%0d", k), b, m, e, 6'($urandom_range(0, 40)),
             int'($urandom_range(1, 40)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
